sfx_engine: RTL



---
 rtl/sfx_pkg.sv | 34 +++
 rtl/sfx_voice.sv | 82 ++++++++
 rtl/sfx_engine.sv | 119 +++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// Shared constants and helpers for the sound-effect engine.
package sfx_pkg;

    localparam int unsigned VEC_W     = 256;
    localparam int unsigned FIELD_W   = 32;
    localparam int unsigned DEF_CNT_W = 20;
    localparam int unsigned DEF_DUR_W = 24;

    // Per-effect default voice programming.
    typedef struct packed {
        logic [DEF_CNT_W-1:0] half_period;
        logic [DEF_DUR_W-1:0] duration;
        logic [DEF_CNT_W-1:0] sweep_step;
    } sfx_cfg_t;

    localparam sfx_cfg_t SFX_SHOT = '{half_period: 20'd524288, duration: 24'd12000000, sweep_step: 20'd0};
    localparam sfx_cfg_t SFX_HIT  = '{half_period: 20'd65536,  duration: 24'd12000000, sweep_step: 20'd0};
    localparam sfx_cfg_t SFX_UFO  = '{half_period: 20'd32768,  duration: 24'd6000000,  sweep_step: 20'd256};

    // Extract channel idx's w-bit field from a packed per-channel vector.
    function automatic logic [FIELD_W-1:0] ch_field(input logic [VEC_W-1:0] vec,
                                                    input int unsigned     idx,
                                                    input int unsigned     w);
        logic [VEC_W-1:0]   sh;
        logic [FIELD_W-1:0] r;
        sh = vec >> (idx * w);
        r  = FIELD_W'(sh);
        if (w < FIELD_W) begin
            r = r & ((FIELD_W'(1) << w) - FIELD_W'(1));
        end
        return r;
    endfunction

endpackage

// File: rtl/sfx_voice.sv
// One tone voice: duration countdown, square-wave divider and saturating pitch sweep.
module sfx_voice
    import sfx_pkg::*;
#(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned DUR_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [CNT_W-1:0] half_period,
    input  logic [DUR_W-1:0] duration,
    input  logic [CNT_W-1:0] sweep_step,
    input  logic             sweep_tick,
    output logic             active,
    output logic             active_nxt_c,
    output logic             tone_nxt_c
);

    logic             tone;
    logic [DUR_W-1:0] remaining;
    logic [DUR_W-1:0] rem_nxt;
    logic [CNT_W-1:0] tone_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cur_hp;
    logic [CNT_W-1:0] hp_nxt;
    logic [CNT_W:0]   hp_sum;

    assign hp_sum = {1'b0, cur_hp} + {1'b0, sweep_step};

    // Next-state: start wins, then kill/expiry, then normal run.
    always_comb begin
        active_nxt_c = active;
        tone_nxt_c   = tone;
        rem_nxt      = remaining;
        cnt_nxt      = tone_cnt;
        hp_nxt       = cur_hp;
        if (start) begin
            active_nxt_c = 1'b1;
            tone_nxt_c   = 1'b0;
            rem_nxt      = duration;
            cnt_nxt      = '0;
            hp_nxt       = (half_period == '0) ? CNT_W'(1) : half_period;
        end else if (kill || (active && (remaining == DUR_W'(1)))) begin
            active_nxt_c = 1'b0;
            tone_nxt_c   = 1'b0;
            rem_nxt      = '0;
            cnt_nxt      = '0;
        end else if (active) begin
            rem_nxt = remaining - DUR_W'(1);
            // >= so a counter left past the new terminal value toggles at once
            if (tone_cnt >= (cur_hp - CNT_W'(1))) begin
                cnt_nxt    = '0;
                tone_nxt_c = ~tone;
            end else begin
                cnt_nxt = tone_cnt + CNT_W'(1);
            end
            if (sweep_tick) begin
                hp_nxt = hp_sum[CNT_W] ? '1 : hp_sum[CNT_W-1:0];
            end
        end
    end

    // Voice state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active    <= 1'b0;
            tone      <= 1'b0;
            remaining <= '0;
            tone_cnt  <= '0;
            cur_hp    <= '0;
        end else begin
            active    <= active_nxt_c;
            tone      <= tone_nxt_c;
            remaining <= rem_nxt;
            tone_cnt  <= cnt_nxt;
            cur_hp    <= hp_nxt;
        end
    end

endmodule

// File: rtl/sfx_engine.sv
// Multi-voice sound-effect generator with fixed-priority output mux.
module sfx_engine
    import sfx_pkg::*;
#(
    parameter int unsigned               NUM_CH        = 2,
    parameter int unsigned               CNT_W         = 20,
    parameter int unsigned               DUR_W         = 24,
    parameter logic [NUM_CH*CNT_W-1:0]   HALF_PERIOD   = {SFX_HIT.half_period, SFX_SHOT.half_period},
    parameter logic [NUM_CH*DUR_W-1:0]   DURATION      = {SFX_HIT.duration, SFX_SHOT.duration},
    parameter logic [NUM_CH*CNT_W-1:0]   SWEEP_STEP    = {SFX_HIT.sweep_step, SFX_SHOT.sweep_step},
    parameter logic [15:0]               SWEEP_DIV     = 16'd50000,
    parameter bit                        PREEMPT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig,
    input  logic              mute,
    output logic              pin,
    output logic [NUM_CH-1:0] active,
    output logic              busy
);

    logic [NUM_CH-1:0] dur_nz;
    logic [NUM_CH-1:0] elig_c;
    logic [NUM_CH-1:0] start_c;
    logic [NUM_CH-1:0] kill_c;
    logic [NUM_CH-1:0] act_nxt_c;
    logic [NUM_CH-1:0] tone_nxt_c;
    logic              pin_nxt_c;

    // Start arbitration and preemption of lower voices.
    always_comb begin
        elig_c  = trig & ~active & dur_nz;
        start_c = '0;
        kill_c  = '0;
        if (PREEMPT_CLEAR) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (elig_c[i]) begin
                    start_c    = '0;
                    start_c[i] = 1'b1;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (start_c[i]) begin
                    for (int j = 0; j < i; j++) begin
                        kill_c[j] = 1'b1;
                    end
                end
            end
        end else begin
            start_c = elig_c;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
        localparam logic [CNT_W-1:0] HP   = CNT_W'(ch_field(VEC_W'(HALF_PERIOD), g, CNT_W));
        localparam logic [DUR_W-1:0] DUR  = DUR_W'(ch_field(VEC_W'(DURATION), g, DUR_W));
        localparam logic [CNT_W-1:0] STEP = CNT_W'(ch_field(VEC_W'(SWEEP_STEP), g, CNT_W));

        logic [15:0] sw_cnt;
        logic        sweep_tick_c;

        assign dur_nz[g]    = (DUR != '0);
        assign sweep_tick_c = active[g] && (sw_cnt == (SWEEP_DIV - 16'd1));

        // Sweep prescaler aligned to this voice's start.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sw_cnt <= '0;
            end else if (start_c[g] || sweep_tick_c) begin
                sw_cnt <= '0;
            end else if (active[g]) begin
                sw_cnt <= sw_cnt + 16'd1;
            end
        end

        sfx_voice #(
            .CNT_W (CNT_W),
            .DUR_W (DUR_W)
        ) u_voice (
            .clk          (clk),
            .rst          (rst),
            .start        (start_c[g]),
            .kill         (kill_c[g]),
            .half_period  (HP),
            .duration     (DUR),
            .sweep_step   (STEP),
            .sweep_tick   (sweep_tick_c),
            .active       (active[g]),
            .active_nxt_c (act_nxt_c[g]),
            .tone_nxt_c   (tone_nxt_c[g])
        );
    end

    // Highest active voice (post-edge state) drives the pin.
    always_comb begin
        pin_nxt_c = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (act_nxt_c[i]) begin
                pin_nxt_c = tone_nxt_c[i];
            end
        end
        if (mute) begin
            pin_nxt_c = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pin  <= 1'b0;
            busy <= 1'b0;
        end else begin
            pin  <= pin_nxt_c;
            busy <= |act_nxt_c;
        end
    end

endmodule
